// File: rtl/vga_frame_analyzer_if.sv
// Pixel stream in, per-frame geometry and key-colour box results out.
interface vga_frame_analyzer_if;
    logic       iHS;
    logic       iVS;
    logic       iBLANK_n;
    logic [7:0] iB;
    logic [7:0] iG;
    logic [7:0] iR;
    logic       oFRAME_DONE;
    logic [9:0] oWIDTH;
    logic [9:0] oHEIGHT;
    logic       oBOX_FOUND;
    logic [9:0] oBOX_X0;
    logic [9:0] oBOX_Y0;
    logic [9:0] oBOX_X1;
    logic [9:0] oBOX_Y1;
    logic       oERR;
    logic [15:0] oFRAME_CNT;

    modport master (
        output iHS, iVS, iBLANK_n, iB, iG, iR,
        input  oFRAME_DONE, oWIDTH, oHEIGHT, oBOX_FOUND,
        input  oBOX_X0, oBOX_Y0, oBOX_X1, oBOX_Y1,
        input  oERR, oFRAME_CNT
    );

    modport slave (
        input  iHS, iVS, iBLANK_n, iB, iG, iR,
        output oFRAME_DONE, oWIDTH, oHEIGHT, oBOX_FOUND,
        output oBOX_X0, oBOX_Y0, oBOX_X1, oBOX_Y1,
        output oERR, oFRAME_CNT
    );
endinterface

// File: rtl/vga_frame_analyzer.sv
// Measures VGA frame geometry and the bounding box of key-colour pixels,
// reporting once per frame at the falling edge of vertical sync.
module vga_frame_analyzer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter logic [7:0]  KEY_B    = 8'hff,
    parameter logic [7:0]  KEY_G    = 8'h00,
    parameter logic [7:0]  KEY_R    = 8'h00
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST,
    vga_frame_analyzer_if.slave  vga
);
    localparam logic [9:0]  LP_H   = 10'(H_ACTIVE);
    localparam logic [9:0]  LP_V   = 10'(V_ACTIVE);
    localparam logic [9:0]  LP_SAT = 10'h3ff;
    localparam logic [9:0]  LP_PRE = 10'h3fe;
    localparam logic [23:0] LP_KEY = {KEY_B, KEY_G, KEY_R};

    typedef enum logic {WAIT_SYNC, IN_FRAME} state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_vs_q;
    logic        r_blank_q;
    logic [9:0]  r_x, r_y, r_width;
    logic [9:0]  r_x0, r_y0, r_x1, r_y1;
    logic        r_found, r_err;
    logic        r_done;
    logic [9:0]  r_o_width, r_o_height;
    logic        r_o_found, r_o_err;
    logic [9:0]  r_o_x0, r_o_y0, r_o_x1, r_o_y1;
    logic [15:0] r_o_cnt;

    logic w_frame_edge, w_line_end, w_key;
    logic w_report, w_acc, w_err_close;

    assign w_frame_edge = !vga.iVS && r_vs_q;
    assign w_line_end   = !vga.iBLANK_n && r_blank_q;
    assign w_key = vga.iBLANK_n &&
                   ({vga.iB, vga.iG, vga.iR} == LP_KEY);

    // An open line or a live pixel at the edge means the frame was cut short.
    assign w_err_close = r_err || (r_y != LP_V) ||
                         vga.iBLANK_n || r_blank_q;

    always_comb begin
        w_state_nx = r_state;
        w_report   = 1'b0;
        w_acc      = 1'b0;
        unique case (r_state)
            WAIT_SYNC: begin
                if (w_frame_edge) w_state_nx = IN_FRAME;
            end
            IN_FRAME: begin
                w_report = w_frame_edge;
                w_acc    = !w_frame_edge;
            end
            default: w_state_nx = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_state    <= WAIT_SYNC;
            r_vs_q     <= 1'b1;
            r_blank_q  <= 1'b0;
            r_done     <= 1'b0;
            r_o_width  <= '0;
            r_o_height <= '0;
            r_o_found  <= 1'b0;
            r_o_err    <= 1'b0;
            r_o_x0     <= '0;
            r_o_y0     <= '0;
            r_o_x1     <= '0;
            r_o_y1     <= '0;
            r_o_cnt    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_vs_q    <= vga.iVS;
            r_blank_q <= vga.iBLANK_n;
            r_done    <= w_report;
            if (w_report) begin
                r_o_width  <= r_width;
                r_o_height <= r_y;
                r_o_found  <= r_found;
                r_o_err    <= w_err_close;
                r_o_x0     <= r_found ? r_x0 : '0;
                r_o_y0     <= r_found ? r_y0 : '0;
                r_o_x1     <= r_found ? r_x1 : '0;
                r_o_y1     <= r_found ? r_y1 : '0;
                r_o_cnt    <= r_o_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST || w_frame_edge) begin
            r_x     <= '0;
            r_y     <= '0;
            r_width <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_found <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_acc) begin
            if (vga.iBLANK_n) begin
                if (r_x != LP_SAT) r_x <= r_x + 10'd1;
                if (r_x >= LP_PRE) r_err <= 1'b1;
                if (w_key) begin
                    r_found <= 1'b1;
                    if (!r_found || r_x < r_x0) r_x0 <= r_x;
                    if (!r_found || r_y < r_y0) r_y0 <= r_y;
                    if (!r_found || r_x > r_x1) r_x1 <= r_x;
                    if (!r_found || r_y > r_y1) r_y1 <= r_y;
                end
            end else if (w_line_end) begin
                r_x     <= '0;
                r_width <= r_x;
                if (r_x != LP_H) r_err <= 1'b1;
                if (r_y != LP_SAT) r_y <= r_y + 10'd1;
                if (r_y >= LP_PRE) r_err <= 1'b1;
            end
        end
    end

    assign vga.oFRAME_DONE = r_done;
    assign vga.oWIDTH      = r_o_width;
    assign vga.oHEIGHT     = r_o_height;
    assign vga.oBOX_FOUND  = r_o_found;
    assign vga.oBOX_X0     = r_o_x0;
    assign vga.oBOX_Y0     = r_o_y0;
    assign vga.oBOX_X1     = r_o_x1;
    assign vga.oBOX_Y1     = r_o_y1;
    assign vga.oERR        = r_o_err;
    assign vga.oFRAME_CNT  = r_o_cnt;
endmodule
